pmci_spi_csr_bridge: RTL and testbench

Host-facing CSR slave for the PMCI SPI indirect-access window at offsets 0x400–0x40C, relative to the PMCI DFH base 0x80000. It decodes host CSR reads and writes of SPI_CSR, SPI_AR, SPI_RD_DR and SPI_WR_DR. It converts command-bit writes into single Avalon-MM read/write transactions toward the downstream PMCI SPI master (BMC side). A timeout watchdog guards each transaction, and busy/error status is reported back to the host.

---
 rtl/pmci_spi_csr_bridge.sv | 129 ++++++++++++
 tb/tb_pmci_spi_csr_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmci_spi_csr_bridge.sv
// pmci_spi_csr_bridge: host CSR window (SPI_CSR/AR/RD_DR/WR_DR) turned into single
// Avalon-MM transactions toward the PMCI SPI master, with a per-transaction watchdog.
module pmci_spi_csr_bridge #(
    parameter int AVM_ADDR_W  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_wr,
    input  logic                  csr_rd,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_rvalid,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_write,
    output logic                  avm_read,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest
);
    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    state_t      state;
    logic [31:0] rd_dr;
    logic [15:0] cnt;
    logic        err;
    logic        busy;
    logic        sel_csr, sel_ar, sel_rd, sel_wr;
    logic        expired;
    logic [31:0] rd_mux;

    assign busy    = state != IDLE;
    assign sel_csr = csr_addr == 12'h400;
    assign sel_ar  = csr_addr == 12'h404;
    assign sel_rd  = csr_addr == 12'h408;
    assign sel_wr  = csr_addr == 12'h40C;
    // >= so a read accepted on the last cycle still aborts if no data follows
    assign expired = cnt >= 16'(TIMEOUT_CYC - 1);

    always_comb begin
        rd_mux = sel_csr ? {28'd0, err, busy, 2'b00} :
                 sel_ar  ? 32'(avm_address) :
                 sel_rd  ? rd_dr :
                 sel_wr  ? avm_writedata : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            csr_rdata     <= '0;
            csr_rvalid    <= 1'b0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= '0;
            rd_dr         <= '0;
            cnt           <= '0;
            err           <= 1'b0;
        end else begin
            csr_rvalid <= csr_rd;
            csr_rdata  <= csr_rd ? rd_mux : 32'd0;
            // W1C first so any later error set in this cycle wins
            if (csr_wr && sel_csr && csr_wdata[3])
                err <= 1'b0;
            if (!busy && csr_wr && sel_ar)
                avm_address <= csr_wdata[AVM_ADDR_W-1:0];
            if (!busy && csr_wr && sel_wr)
                avm_writedata <= csr_wdata;
            if (busy)
                cnt <= cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (csr_wr && sel_csr) begin
                        if (csr_wdata[1:0] == 2'b11) begin
                            err <= 1'b1;
                        end else if (csr_wdata[0]) begin
                            state     <= WR_REQ;
                            avm_write <= 1'b1;
                            cnt       <= '0;
                        end else if (csr_wdata[1]) begin
                            state    <= RD_REQ;
                            avm_read <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= IDLE;
                    end else if (expired) begin
                        avm_write <= 1'b0;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (avm_readdatavalid) begin
                            rd_dr <= avm_readdata;
                            state <= IDLE;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end else if (expired) begin
                        avm_read <= 1'b0;
                        err      <= 1'b1;
                        rd_dr    <= 32'hFFFF_FFFF;
                        state    <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        rd_dr <= avm_readdata;
                        state <= IDLE;
                    end else if (expired) begin
                        err   <= 1'b1;
                        rd_dr <= 32'hFFFF_FFFF;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmci_spi_csr_bridge.sv
// tb_pmci_spi_csr_bridge: randomized scenarios checked against a register-level model
// of the SPI CSR window (AR, WR_DR, RD_DR, ERR) with spec-derived timing expectations.
module tb_pmci_spi_csr_bridge;
    localparam int AW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          csr_wr = 1'b0, csr_rd = 1'b0;
    logic [11:0]   csr_addr = '0;
    logic [31:0]   csr_wdata = '0;
    logic [31:0]   csr_rdata;
    logic          csr_rvalid;
    logic [AW-1:0] avm_address;
    logic          avm_write, avm_read;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest = 1'b1;

    int checks = 0, errors = 0;
    logic [31:0] m_ar = '0, m_wr = '0, m_rd = '0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    pmci_spi_csr_bridge #(.AVM_ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_reg(input logic [11:0] a);
        return a == 12'h400 ? {28'h0, m_err, 3'b000} :
               a == 12'h404 ? m_ar :
               a == 12'h408 ? m_rd :
               a == 12'h40C ? m_wr : 32'h0;
    endfunction

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_wr = 1'b0;
    endtask

    // ok: rvalid high exactly one cycle after the strobe, low (with rdata 0) the next
    task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic ok);
        logic v1;
        csr_rd = 1'b1; csr_addr = a;
        @(negedge clk);
        v1 = csr_rvalid; d = csr_rdata; csr_rd = 1'b0;
        @(negedge clk);
        ok = v1 && !csr_rvalid && csr_rdata == 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ok; logic [11:0] a;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (avm_write !== 1'b0 || avm_read !== 1'b0 || csr_rvalid !== 1'b0 || avm_address !== '0 ||
            avm_writedata !== '0 || csr_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs got w=%b r=%b rv=%b a=%h wd=%h rd=%h exp all zero",
                     avm_write, avm_read, csr_rvalid, avm_address, avm_writedata, csr_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        m_ar = 0; m_wr = 0; m_rd = 0; m_err = 0;
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL reset_reg[%h] got %h rvalid_ok=%0b exp %h", a, d, ok, exp_reg(a));
            end
        end
    endtask

    task automatic test_write(input logic [15:0] adr, input logic [31:0] dat, input int n);
        logic [31:0] d; logic ok; logic [11:0] a; int hi; logic bad; int exp_hi;
        csr_write(12'h404, {16'($urandom), adr}); m_ar = {16'h0, adr};
        csr_write(12'h40C, dat); m_wr = dat;
        avm_waitrequest = 1'b1;
        csr_write(12'h400, 32'h1);
        hi = 0; bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!avm_write) break;
            hi++;
            if (avm_address !== adr || avm_writedata !== dat) bad = 1'b1;
            if (k == n) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        avm_waitrequest = 1'b1;
        exp_hi = n < TO ? n + 1 : TO;
        if (n >= TO) m_err = 1'b1;
        checks++;
        if (hi != exp_hi || bad) begin
            errors++;
            $display("FAIL write_hold got %0d cycles bad=%0b exp %0d stable cycles", hi, bad, exp_hi);
        end
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL write_reg[%h] n=%0d got %h rvalid_ok=%0b exp %h", a, n, d, ok, exp_reg(a));
            end
        end
        if (m_err) begin csr_write(12'h400, 32'h8); m_err = 1'b0; end
    endtask

    task automatic test_read(input logic [15:0] adr, input logic [31:0] dat, input int w, input int l);
        logic [31:0] d, st; logic ok, rv; logic [11:0] a; int hi;
        csr_write(12'h404, {16'h0, adr}); m_ar = {16'h0, adr};
        avm_waitrequest = 1'b1;
        csr_write(12'h400, 32'h2);
        hi = 0; rv = 1'b0; st = '0;
        for (int c = 0; c <= w + l; c++) begin
            if (avm_read && avm_address === adr) hi++;
            avm_waitrequest   = (c != w);
            avm_readdatavalid = (c == w + l);
            avm_readdata      = (c == w + l) ? dat : $urandom;
            csr_rd = (c == w + l); csr_addr = 12'h400;
            @(negedge clk);
            if (c == w + l) begin rv = csr_rvalid; st = csr_rdata; end
        end
        csr_rd = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b1;
        @(negedge clk);
        m_rd = dat;
        checks++;
        if (hi != w + 1) begin
            errors++;
            $display("FAIL read_hold got %0d cycles exp %0d", hi, w + 1);
        end
        checks++;
        if (!rv || st !== {28'h0, m_err, 3'b100}) begin
            errors++;
            $display("FAIL read_busy_pre_edge got rv=%0b csr=%h exp rv=1 csr=%h", rv, st, {28'h0, m_err, 3'b100});
        end
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL read_reg[%h] w=%0d l=%0d got %h rvalid_ok=%0b exp %h", a, w, l, d, ok, exp_reg(a));
            end
        end
    endtask

    task automatic test_timeout(input logic is_write, input logic accept);
        logic [31:0] d, last; logic ok; logic [11:0] a; int busy_n; logic done;
        avm_waitrequest = 1'b1;
        csr_write(12'h400, is_write ? 32'h1 : 32'h2);
        if (accept) avm_waitrequest = 1'b0;
        csr_rd = 1'b1; csr_addr = 12'h400;
        busy_n = 0; done = 1'b0; last = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            avm_waitrequest = 1'b1;
            last = csr_rdata;
            if (csr_rdata[2]) busy_n++; else done = 1'b1;
        end
        csr_rd = 1'b0;
        @(negedge clk);
        m_err = 1'b1;
        if (!is_write) m_rd = 32'hFFFF_FFFF;
        checks++;
        if (!done || busy_n != TO || last !== 32'h8) begin
            errors++;
            $display("FAIL timeout_busy wr=%0b acc=%0b got %0d busy cycles csr=%h exp %0d and csr=8",
                     is_write, accept, busy_n, last, TO);
        end
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL timeout_reg[%h] got %h rvalid_ok=%0b exp %h", a, d, ok, exp_reg(a));
            end
        end
        csr_write(12'h400, 32'h8); m_err = 1'b0;
        csr_read(12'h400, d, ok);
        checks++;
        if (!ok || d !== 32'h0) begin
            errors++;
            $display("FAIL timeout_w1c got %h rvalid_ok=%0b exp 00000000", d, ok);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d, dat; logic ok; logic [11:0] a; logic spur;
        csr_write(12'h400, 32'h3); m_err = 1'b1;
        avm_waitrequest = 1'b1;
        csr_write(12'h400, 32'h2);
        csr_write(12'h404, 32'h7);
        csr_write(12'h40C, $urandom);
        csr_write(12'h400, 32'h9);
        m_err = 1'b0;
        dat = $urandom;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = dat;
        @(negedge clk);
        avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
        m_rd = dat;
        spur = 1'b0;
        repeat (10) begin
            if (avm_write || avm_read) spur = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (spur) begin
            errors++;
            $display("FAIL busy_no_cmd got a request after completion exp none");
        end
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL busy_reg[%h] got %h rvalid_ok=%0b exp %h", a, d, ok, exp_reg(a));
            end
        end
    endtask

    task automatic test_both_set();
        logic [31:0] d; logic ok; logic spur;
        logic [31:0] v [3] = '{32'h3, 32'hB, 32'h7};
        for (int j = 0; j < 3; j++) begin
            csr_write(12'h400, v[j]);
            spur = 1'b0;
            repeat (5) begin
                if (avm_write || avm_read) spur = 1'b1;
                @(negedge clk);
            end
            m_err = 1'b1;
            csr_read(12'h400, d, ok);
            checks++;
            if (spur || !ok || d !== exp_reg(12'h400)) begin
                errors++;
                $display("FAIL both_set[%h] got csr=%h req=%0b rvalid_ok=%0b exp csr=%h no req", v[j], d, spur, ok, exp_reg(12'h400));
            end
            csr_write(12'h400, 32'h8); m_err = 1'b0;
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic ok; logic [11:0] a, u;
        for (int j = 0; j < 6; j++) begin
            u = j == 0 ? 12'h401 : j == 1 ? 12'h410 : 12'($urandom);
            if (u == 12'h400 || u == 12'h404 || u == 12'h408 || u == 12'h40C) u = 12'h3FC;
            csr_write(u, $urandom);
            csr_read(u, d, ok);
            checks++;
            if (!ok || d !== 32'h0) begin
                errors++;
                $display("FAIL unmapped[%h] got %h rvalid_ok=%0b exp 00000000", u, d, ok);
            end
        end
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL unmapped_reg[%h] got %h rvalid_ok=%0b exp %h", a, d, ok, exp_reg(a));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic ok; logic [11:0] a;
        csr_write(12'h40C, $urandom);
        avm_waitrequest = 1'b1;
        csr_write(12'h400, 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (avm_read !== 1'b0 || avm_address !== '0) begin
            errors++;
            $display("FAIL reset_abort got read=%b addr=%h exp 0 0", avm_read, avm_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ar = 0; m_wr = 0; m_rd = 0; m_err = 0;
        avm_readdatavalid = 1'b1; avm_readdata = $urandom | 32'h1;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 12'h400 + 12'(4 * i);
            csr_read(a, d, ok);
            checks++;
            if (!ok || d !== exp_reg(a)) begin
                errors++;
                $display("FAIL reset_abort_reg[%h] got %h rvalid_ok=%0b exp %h", a, d, ok, exp_reg(a));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 10; j++) begin
            if ($urandom_range(0, 1) == 0)
                test_write(16'($urandom), $urandom, $urandom_range(0, 6));
            else
                test_read(16'($urandom), $urandom, $urandom_range(0, 6), $urandom_range(0, 6));
        end
    endtask

    initial begin
        test_reset();
        test_write(16'h0123, 32'hA5A5_5A5A, 3);
        test_read(16'h0040, 32'hCAFE_F00D, 0, 5);
        test_timeout(1'b0, 1'b0);
        test_timeout(1'b0, 1'b1);
        test_timeout(1'b1, 1'b0);
        test_busy_ignore();
        test_both_set();
        test_write(16'($urandom), $urandom, TO - 1);
        test_write(16'($urandom), $urandom, TO);
        test_read(16'($urandom), $urandom, 3, TO - 4);
        test_read(16'($urandom), $urandom, TO - 1, 0);
        test_unmapped();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
